// File: rtl/toggle_monitor_pkg.sv
// Shared definitions for the toggle monitor: FSM state encodings and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package toggle_monitor_pkg;

  // Run-tracking FSM states; encodings are fixed so debug readouts stay stable
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_COUNT_W     = 16;
  localparam int DEF_LEN_W       = 8;
  localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/toggle_monitor_sync_flop.sv
// Generic multi-flop synchronizer for asynchronous inputs into the clock domain.
// Latency: STAGES clocks from d to q.
// Backpressure: none; samples every clock.
module sync_flop
  import toggle_monitor_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES,
  parameter int WIDTH  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the asynchronous input through the flop chain; oldest stage is the output
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_monitor.sv
// Synchronizes a toggle signal, emits rise/fall pulses, counts edges, captures run lengths, flags stuck.
// Latency: sig_in change to pulse/counter update is SYNC_STAGES+1 clocks.
// Backpressure: none; free-running monitor, outputs are status only.
module toggle_monitor
  import toggle_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sig_in,
  input  logic               clear,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic [COUNT_W-1:0] edge_count,
  output logic [LEN_W-1:0]   last_high_len,
  output logic [LEN_W-1:0]   last_low_len,
  output logic               len_valid,
  output logic               stuck,
  output logic               stuck_level
);

  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] TIMEOUT_L = LEN_W'(TIMEOUT);

  logic             s;
  logic             s_d;
  logic             rise;
  logic             fall;
  logic             edge_seen;
  logic             timed_out;
  logic [LEN_W-1:0] run_len;
  state_t           state;

  sync_flop #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (sig_in),
    .q       (s)
  );

  assign rise      = s & ~s_d;
  assign fall      = ~s & s_d;
  assign edge_seen = rise | fall;
  // An edge in the same cycle as the timeout threshold wins over the timeout
  assign timed_out = ~edge_seen & (run_len >= TIMEOUT_L);
  assign stuck     = (state == ST_STUCK);

  // Edge detector and registered pulses; deliberately blind to clear and FSM state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_d        <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s_d        <= s;
      rise_pulse <= rise;
      fall_pulse <= fall;
    end
  end

  // Edge counter (wrapping) and current run length (saturating, restarts at 1 on an edge)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_count <= '0;
      run_len    <= '0;
    end else if (clear) begin
      edge_count <= '0;
      run_len    <= '0;
    end else if (edge_seen) begin
      edge_count <= edge_count + COUNT_W'(1);
      run_len    <= LEN_W'(1);
    end else if (run_len != LEN_MAX) begin
      run_len    <= run_len + LEN_W'(1);
    end
  end

  // Run-tracking FSM: captures complete run lengths, enters STUCK after a quiet period
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      last_high_len <= '0;
      last_low_len  <= '0;
      len_valid     <= 1'b0;
      stuck_level   <= 1'b0;
    end else if (clear) begin
      state         <= ST_IDLE;
      last_high_len <= '0;
      last_low_len  <= '0;
      len_valid     <= 1'b0;
      stuck_level   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // First run after reset/clear is partial, so it is never captured
          if (rise) begin
            state <= ST_HIGH;
          end else if (timed_out) begin
            state       <= ST_STUCK;
            stuck_level <= s;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state         <= ST_LOW;
            last_high_len <= run_len;
            len_valid     <= 1'b1;
          end else if (timed_out) begin
            state       <= ST_STUCK;
            stuck_level <= s;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state        <= ST_HIGH;
            last_low_len <= run_len;
            len_valid    <= 1'b1;
          end else if (timed_out) begin
            state       <= ST_STUCK;
            stuck_level <= s;
          end
        end
        ST_STUCK: begin
          // Leaving STUCK starts a fresh run; the stuck run itself is not captured
          if (rise) begin
            state <= ST_HIGH;
          end else if (fall) begin
            state <= ST_LOW;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// Self-checking bench for toggle_monitor: scoreboard of expected pulses plus directed checks.
// Latency: expects each pulse SYNC_STAGES+1 clocks after the sig_in change.
// Backpressure: n/a.
module tb_toggle_monitor;
  import toggle_monitor_pkg::*;

  localparam int LAT     = 3;   // SYNC_STAGES + 1 with defaults
  localparam int TIMEOUT = 64;

  logic        clock;
  logic        reset_n;
  logic        sig_in;
  logic        clear;
  logic        rise_pulse, fall_pulse, len_valid, stuck, stuck_level;
  logic [15:0] edge_count;
  logic [7:0]  last_high_len, last_low_len;
  logic        rise_pulse4, fall_pulse4, len_valid4, stuck4, stuck_level4;
  logic [3:0]  edge_count4;
  logic [7:0]  last_high_len4, last_low_len4;

  toggle_monitor dut (
    .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .clear(clear),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .edge_count(edge_count),
    .last_high_len(last_high_len), .last_low_len(last_low_len),
    .len_valid(len_valid), .stuck(stuck), .stuck_level(stuck_level)
  );

  toggle_monitor #(.COUNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .clear(clear),
    .rise_pulse(rise_pulse4), .fall_pulse(fall_pulse4), .edge_count(edge_count4),
    .last_high_len(last_high_len4), .last_low_len(last_low_len4),
    .len_valid(len_valid4), .stuck(stuck4), .stuck_level(stuck_level4)
  );

  typedef struct {
    logic        is_rise;
    int          cyc;
    logic [15:0] cnt;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        lv;
    logic        lvl;
  } sb_t;

  sb_t sb[$];
  sb_t mon_rec;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;

  // Reference model state
  state_t      mstate;
  logic [15:0] mcount;
  logic [7:0]  mhi, mlo;
  logic        mlv, mlevel;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mstate = ST_IDLE;
    mcount = '0;
    mhi    = '0;
    mlo    = '0;
    mlv    = 1'b0;
    mlevel = 1'b0;
  endtask

  // Drive a new level at the current negedge, predict the resulting pulse, then hold.
  // With clr set, clear is raised for the cycle in which the synced edge is seen.
  task automatic toggle_to(input logic v, input int hold, input logic clr);
    sb_t r;
    int  len;
    len = cyc - last_cyc;
    if (len > 255) len = 255;
    mcount = mcount + 16'd1;
    if (mstate != ST_STUCK && len > TIMEOUT) begin
      mstate = ST_STUCK;
      mlevel = sig_in;
    end
    if (clr) begin
      model_reset();
    end else begin
      case (mstate)
        ST_IDLE:  if (v) mstate = ST_HIGH;
        ST_HIGH:  if (!v) begin mhi = 8'(len); mlv = 1'b1; mstate = ST_LOW; end
        ST_LOW:   if (v) begin mlo = 8'(len); mlv = 1'b1; mstate = ST_HIGH; end
        default:  mstate = v ? ST_HIGH : ST_LOW;
      endcase
    end
    r.is_rise = v;
    r.cyc     = cyc + LAT;
    r.cnt     = mcount;
    r.hi      = mhi;
    r.lo      = mlo;
    r.lv      = mlv;
    r.lvl     = mlevel;
    sb.push_back(r);
    last_cyc = cyc;
    sig_in   = v;
    if (clr) begin
      repeat (LAT - 1) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      repeat (hold - LAT) @(negedge clock);
    end else begin
      repeat (hold) @(negedge clock);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {rise_pulse, fall_pulse, stuck, stuck_level, len_valid,
                           last_high_len, last_low_len, edge_count4}, 32'd0);
    check({tag, "_count"}, edge_count, 32'd0);
  endtask

  // Scoreboard consumer: every observed pulse must match the oldest prediction
  always @(negedge clock) begin
    if (reset_n && (rise_pulse || fall_pulse)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", sb.size(), 1);
      end else begin
        mon_rec = sb.pop_front();
        check("pulse_dir",   rise_pulse, mon_rec.is_rise);
        check("pulse_excl",  rise_pulse & fall_pulse, 0);
        check("latency",     cyc, mon_rec.cyc);
        check("edge_count",  edge_count, mon_rec.cnt);
        check("edge_count4", edge_count4, mon_rec.cnt[3:0]);
        check("high_len",    last_high_len, mon_rec.hi);
        check("low_len",     last_low_len, mon_rec.lo);
        check("len_valid",   len_valid, mon_rec.lv);
        check("stuck_clr",   stuck, 0);
        check("stuck_level", stuck_level, mon_rec.lvl);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    sig_in  = 1'b0;
    clear   = 1'b0;
    model_reset();

    // Power-on reset state
    repeat (3) @(negedge clock);
    check_all_zero("por");
    reset_n  = 1'b1;
    last_cyc = cyc;
    repeat (2) @(negedge clock);

    // Regular toggling every 3 clocks, 20 edges (also wraps the 4-bit counter)
    for (int i = 0; i < 20; i++) toggle_to((i % 2) == 0, 3, 1'b0);
    check("t2_high_len", last_high_len, 3);
    check("t2_low_len",  last_low_len, 3);
    check("t2_len_valid", len_valid, 1);
    check("t2_count",    edge_count, 20);
    check("t2_count4",   edge_count4, 4);

    // One-cycle high pulse from LOW
    toggle_to(1'b1, 1, 1'b0);
    toggle_to(1'b0, 4, 1'b0);
    check("t6_high_len", last_high_len, 1);

    // Hold high past the timeout
    toggle_to(1'b1, 3, 1'b0);
    repeat (TIMEOUT - 1) @(negedge clock);
    check("t3_not_stuck_yet", stuck, 0);
    @(negedge clock);
    check("t3_stuck", stuck, 1);
    check("t3_stuck_level", stuck_level, 1);
    repeat (36) @(negedge clock);
    check("t3_still_stuck", stuck, 1);
    toggle_to(1'b0, 5, 1'b0);
    check("t3_high_len_kept", last_high_len, 1);
    check("t3_unstuck", stuck, 0);

    // Reset mid-run with sig_in high
    toggle_to(1'b1, 4, 1'b0);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst0");
    repeat (2) begin
      @(negedge clock);
      check_all_zero("rst_hold");
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    mstate = ST_HIGH;
    mcount = 16'd1;
    mlevel = 1'b0;
    mon_rec.is_rise = 1'b1;
    mon_rec.cyc     = cyc + LAT;
    mon_rec.cnt     = 16'd1;
    mon_rec.hi      = 8'd0;
    mon_rec.lo      = 8'd0;
    mon_rec.lv      = 1'b0;
    mon_rec.lvl     = 1'b0;
    sb.push_back(mon_rec);
    last_cyc = cyc;
    repeat (2) begin
      @(negedge clock);
      check_all_zero("post_rst");
    end
    repeat (3) @(negedge clock);
    toggle_to(1'b0, 3, 1'b0);
    check("t1_first_capture", last_high_len, 5);

    // Clear coincident with a synced rise, then edges after clear
    toggle_to(1'b1, 4, 1'b1);
    check("t5_count_cleared", edge_count, 0);
    check("t5_lv_cleared", len_valid, 0);
    toggle_to(1'b0, 4, 1'b0);
    check("t5_count_after", edge_count, 1);
    check("t5_no_capture", len_valid, 0);
    toggle_to(1'b1, 3, 1'b0);
    toggle_to(1'b0, 3, 1'b0);
    check("t5_capture", last_high_len, 3);

    repeat (10) @(negedge clock);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
